// File: rtl/alu_pkg.sv
// Shared ALU definitions.
// Holds the ALU command encodings (also used by the ALU control LUT), the
// divider sequencer state enum and the default datapath width.
// No ports: package only.
package alu_pkg;

   localparam int unsigned ALU_WIDTH = 32;

   localparam logic [2:0] ALU_ADD  = 3'd0;
   localparam logic [2:0] ALU_SUB  = 3'd1;
   localparam logic [2:0] ALU_XOR  = 3'd2;
   localparam logic [2:0] ALU_SLT  = 3'd3;
   localparam logic [2:0] ALU_AND  = 3'd4;
   localparam logic [2:0] ALU_NAND = 3'd5;
   localparam logic [2:0] ALU_NOR  = 3'd6;
   localparam logic [2:0] ALU_OR   = 3'd7;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_RUN  = 2'd1,
      DIV_DONE = 2'd2
   } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step decision.
// Ports:
//   shifted      - partial remainder shifted left with the next dividend bit
//   msb          - bit shifted out of the partial remainder (33rd trial bit)
//   alu_result   - ALU difference shifted - divisor
//   alu_carryout - ALU carry after SUB (1 = no borrow)
//   r_next       - next partial remainder
//   q_bit        - quotient bit produced by this step
module div_step
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = ALU_WIDTH
) (
   input  logic [WIDTH-1:0] shifted,
   input  logic             msb,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_carryout,
   output logic [WIDTH-1:0] r_next,
   output logic             q_bit
);

   // With msb set the 33-bit trial value is >= D whatever the ALU carry says,
   // and the truncated difference is still the exact new remainder.
   always_comb begin
      q_bit  = msb | alu_carryout;
      r_next = q_bit ? alu_result : shifted;
   end

endmodule

// File: rtl/alu_div_sequencer.sv
// Multi-cycle unsigned restoring divider that drives the shared ALU.
// One SUB is issued per iteration; the ALU itself lives outside this block.
// Ports:
//   clk, reset_n            - clock, asynchronous active-low reset
//   start, dividend, divisor - request (sampled only when idle)
//   busy, done              - status (done is a one-cycle pulse)
//   quotient, remainder     - registered results, held until next request
//   div_by_zero             - registered flag, held with results
//   alu_a, alu_b, alu_cmd   - ALU operands and command
//   alu_result, alu_carryout - ALU outputs consumed during RUN
module alu_div_sequencer
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = ALU_WIDTH
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [2:0]       alu_cmd,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_carryout
);

   localparam int unsigned CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   div_state_t       state;
   logic [WIDTH-1:0] r_reg;
   logic [WIDTH-1:0] q_reg;
   logic [WIDTH-1:0] d_reg;
   logic [CW-1:0]    count;

   logic [WIDTH-1:0] shifted;
   logic             msb;
   logic [WIDTH-1:0] r_next;
   logic             q_bit;
   logic [WIDTH-1:0] q_next;

   always_comb begin
      shifted = {r_reg[WIDTH-2:0], q_reg[WIDTH-1]};
      msb     = r_reg[WIDTH-1];
      q_next  = {q_reg[WIDTH-2:0], q_bit};
   end

   div_step #(.WIDTH(WIDTH)) u_step (
      .shifted      (shifted),
      .msb          (msb),
      .alu_result   (alu_result),
      .alu_carryout (alu_carryout),
      .r_next       (r_next),
      .q_bit        (q_bit)
   );

   always_comb begin
      alu_a   = '0;
      alu_b   = '0;
      alu_cmd = ALU_ADD;
      if (state == DIV_RUN) begin
         alu_a   = shifted;
         alu_b   = d_reg;
         alu_cmd = ALU_SUB;
      end
   end

   always_comb begin
      busy = (state != DIV_IDLE);
      done = (state == DIV_DONE);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= DIV_IDLE;
         count       <= '0;
         r_reg       <= '0;
         q_reg       <= '0;
         d_reg       <= '0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         case (state)
            DIV_IDLE: begin
               if (start) begin
                  if (divisor != '0) begin
                     d_reg       <= divisor;
                     q_reg       <= dividend;
                     r_reg       <= '0;
                     count       <= '0;
                     div_by_zero <= 1'b0;
                     state       <= DIV_RUN;
                  end else begin
                     quotient    <= '1;
                     remainder   <= dividend;
                     div_by_zero <= 1'b1;
                     state       <= DIV_DONE;
                  end
               end
            end
            DIV_RUN: begin
               r_reg <= r_next;
               q_reg <= q_next;
               count <= count + 1'b1;
               if (count == LAST) begin
                  // Results come from this final step's values, not the registers.
                  quotient  <= q_next;
                  remainder <= r_next;
                  state     <= DIV_DONE;
               end
            end
            DIV_DONE: state <= DIV_IDLE;
            default:  state <= DIV_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_div_sequencer.sv
module tb_alu_div_sequencer;

   localparam int unsigned W = 32;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          start = 1'b0;
   logic [W-1:0]  dividend = '0;
   logic [W-1:0]  divisor = '0;
   logic          busy, done, div_by_zero;
   logic [W-1:0]  quotient, remainder;
   logic [W-1:0]  alu_a, alu_b, alu_result;
   logic [2:0]    alu_cmd;
   logic          alu_carryout;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   always #5 clk = ~clk;

   alu_div_sequencer #(.WIDTH(W)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .start        (start),
      .dividend     (dividend),
      .divisor      (divisor),
      .busy         (busy),
      .done         (done),
      .quotient     (quotient),
      .remainder    (remainder),
      .div_by_zero  (div_by_zero),
      .alu_a        (alu_a),
      .alu_b        (alu_b),
      .alu_cmd      (alu_cmd),
      .alu_result   (alu_result),
      .alu_carryout (alu_carryout)
   );

   // Behavioural stand-in for the shared ALU (ADD and SUB are all that matter here).
   always_comb begin
      logic [W:0] sum;
      sum = '0;
      case (alu_cmd)
         3'd0: sum = {1'b0, alu_a} + {1'b0, alu_b};
         3'd1: sum = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
         default: sum = '0;
      endcase
      alu_result   = sum[W-1:0];
      alu_carryout = sum[W];
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // mode 0: plain divide; 1: extra start at cycle 10; 2: reset pulse at cycle 20
   task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input int mode);
      logic [W-1:0] exp_q, exp_r;
      int done_cyc, done_cnt, bad_cmd, sub_seen, busy1;
      logic [W-1:0] got_q, got_r;
      logic got_z;
      if (b == 0) begin
         exp_q = '1;
         exp_r = a;
      end else begin
         exp_q = a / b;
         exp_r = a % b;
      end
      done_cyc = 0; done_cnt = 0; bad_cmd = 0; sub_seen = 0; busy1 = 0;
      got_q = '0; got_r = '0; got_z = 1'b0;
      @(negedge clk);
      start = 1'b1; dividend = a; divisor = b;
      @(negedge clk);
      start = 1'b0;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         if (cyc > 1) @(negedge clk);
         if (cyc == 1) busy1 = busy;
         if (mode == 1 && cyc == 10) begin
            start = 1'b1; dividend = $urandom; divisor = $urandom_range(200, 1);
         end
         if (mode == 1 && cyc == 11) start = 1'b0;
         if (mode == 2 && cyc == 20) begin
            reset_n = 1'b0;
            #1;
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
            check("rst_q", quotient, 0);
            check("rst_r", remainder, 0);
            check("rst_dbz", div_by_zero, 0);
         end
         if (done) begin
            done_cnt++;
            if (done_cyc == 0) begin
               done_cyc = cyc;
               got_q = quotient; got_r = remainder; got_z = div_by_zero;
            end
         end
         if (busy && !done && alu_cmd != 3'd1) bad_cmd++;
         if (alu_cmd == 3'd1) sub_seen = 1;
      end
      if (mode == 2) begin
         check("rst_no_done", done_cnt, 0);
         @(negedge clk);
         reset_n = 1'b1;
         @(negedge clk);
         return;
      end
      check($sformatf("busy_c1 %0h/%0h", a, b), busy1, 1);
      check($sformatf("done_cyc %0h/%0h", a, b), done_cyc, (b == 0) ? 1 : 33);
      check($sformatf("done_len %0h/%0h", a, b), done_cnt, 1);
      check($sformatf("quot %0h/%0h", a, b), got_q, exp_q);
      check($sformatf("rem %0h/%0h", a, b), got_r, exp_r);
      check($sformatf("dbz %0h/%0h", a, b), got_z, (b == 0));
      check($sformatf("q_hold %0h/%0h", a, b), quotient, exp_q);
      check($sformatf("r_hold %0h/%0h", a, b), remainder, exp_r);
      if (b == 0) check("dbz_no_sub", sub_seen, 0);
      else        check($sformatf("cmd_sub %0h/%0h", a, b), bad_cmd, 0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_q", quotient, 0);
      check("reset_r", remainder, 0);
      check("reset_dbz", div_by_zero, 0);
      check("reset_alu_cmd", alu_cmd, 0);
      reset_n = 1'b1;
      @(negedge clk);

      run_div(32'd100, 32'd7, 0);
      run_div(32'hFFFF_FFFF, 32'h8000_0000, 0);
      run_div(32'd3, 32'd10, 0);
      run_div(32'hFFFF_FFFF, 32'd1, 0);
      run_div(32'd5, 32'd0, 0);
      run_div(32'd100, 32'd7, 1);
      run_div(32'd100, 32'd7, 2);
      run_div(32'd100, 32'd7, 0);

      for (int i = 0; i < 30; i++) begin
         logic [W-1:0] a, b;
         a = $urandom;
         case (i % 5)
            0: b = $urandom;
            1: b = $urandom_range(255, 1);
            2: b = (i % 10 == 2) ? '0 : ($urandom | 32'h8000_0000);
            3: b = a;
            default: b = $urandom >> $urandom_range(31, 0);
         endcase
         run_div(a, b, 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
